byte_lane_arbiter: RTL and testbench

Round-robin scheduler that shares a single 8-bit byte lane between two 32-bit word requesters and serializes each granted word MSB-byte first on `clk_4f`. It sits upstream of the 32-to-8 unbundling path and decides which source's word is sequenced next. It also provides the per-word pop handshake and lane-pause control that the bare byte demux lacks.

---
 rtl/byte_lane_arbiter.sv | 111 +++++++++++
 tb/tb_byte_lane_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/byte_lane_arbiter.sv
// Two-requester round-robin arbiter that serializes each granted 32-bit word
// onto a shared byte lane, MSB byte first, with per-word pop and lane pause.
module byte_lane_arbiter #(
   parameter int FIRST_PRIORITY = 0
) (
   input  logic        clk_4f,
   input  logic        reset_L,
   input  logic [31:0] data_in0,
   input  logic        valid_in0,
   output logic        pop_0,
   input  logic [31:0] data_in1,
   input  logic        valid_in1,
   output logic        pop_1,
   input  logic        pause,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        src_out,
   output logic [7:0]  words_sent
);

   typedef enum logic [2:0] {IDLE, S3, S2, S1, S0} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_hold;
   logic        r_last_grant;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_src;
   logic [7:0]  r_words;

   logic        w_window;
   logic        w_pop0;
   logic        w_pop1;
   logic        w_pop_any;
   logic [31:0] w_word;

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_pop_any ? S3 : IDLE;
         S3:      w_next = pause ? S3 : S2;
         S2:      w_next = pause ? S2 : S1;
         S1:      w_next = pause ? S1 : S0;
         S0:      w_next = pause ? S0 : (w_pop_any ? S3 : IDLE);
         default: w_next = IDLE;
      endcase
   end

   // Pops depend only on state, pause and the valids, never on data_in.
   always_comb begin
      w_window  = ((r_state == IDLE) || (r_state == S0)) && !pause && reset_L;
      w_pop0    = w_window && valid_in0 && (!valid_in1 || r_last_grant);
      w_pop1    = w_window && valid_in1 && (!valid_in0 || !r_last_grant);
      w_pop_any = w_pop0 || w_pop1;
      w_word    = w_pop1 ? data_in1 : data_in0;
      pop_0     = w_pop0;
      pop_1     = w_pop1;
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         r_hold       <= 32'd0;
         r_last_grant <= (FIRST_PRIORITY == 0) ? 1'b1 : 1'b0;
         r_data       <= 8'd0;
         r_valid      <= 1'b0;
         r_src        <= 1'b0;
      end else if (pause) begin
         r_valid <= 1'b0;
      end else if (w_pop_any) begin
         r_hold       <= w_word;
         r_last_grant <= w_pop1;
         r_data       <= w_word[31:24];
         r_valid      <= 1'b1;
         r_src        <= w_pop1;
      end else begin
         case (r_state)
            S3: begin
               r_data  <= r_hold[23:16];
               r_valid <= 1'b1;
            end
            S2: begin
               r_data  <= r_hold[15:8];
               r_valid <= 1'b1;
            end
            S1: begin
               r_data  <= r_hold[7:0];
               r_valid <= 1'b1;
            end
            default: r_valid <= 1'b0;
         endcase
      end
   end

   // A word counts as sent when the lane leaves its last byte unpaused.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L)                       r_words <= 8'd0;
      else if (!pause && r_state == S0)   r_words <= r_words + 8'd1;
   end

   assign data_out   = r_data;
   assign valid_out  = r_valid;
   assign src_out    = r_src;
   assign words_sent = r_words;

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// Directed bench for byte_lane_arbiter: vector table plus hand sequences for
// async mid-word reset and the words_sent wrap.
module tb_byte_lane_arbiter;

   logic        clk_4f = 1'b0;
   logic        reset_L;
   logic [31:0] data_in0, data_in1;
   logic        valid_in0, valid_in1, pause;
   logic        pop_0, pop_1;
   logic [7:0]  data_out;
   logic        valid_out, src_out;
   logic [7:0]  words_sent;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        v0, v1, pz;
      logic [31:0] d0, d1;
      logic        ep0, ep1;
      logic [7:0]  edo;
      logic        evo, esrc;
      logic [7:0]  ews;
   } vec_t;

   vec_t vec[$];

   byte_lane_arbiter #(.FIRST_PRIORITY(0)) dut (
      .clk_4f     (clk_4f),
      .reset_L    (reset_L),
      .data_in0   (data_in0),
      .valid_in0  (valid_in0),
      .pop_0      (pop_0),
      .data_in1   (data_in1),
      .valid_in1  (valid_in1),
      .pop_1      (pop_1),
      .pause      (pause),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .src_out    (src_out),
      .words_sent (words_sent)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic v0, input logic v1, input logic pz,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic ep0, input logic ep1, input logic [7:0] edo,
                      input logic evo, input logic esrc, input logic [7:0] ews);
      vec_t r;
      r.v0 = v0; r.v1 = v1; r.pz = pz; r.d0 = d0; r.d1 = d1;
      r.ep0 = ep0; r.ep1 = ep1; r.edo = edo; r.evo = evo; r.esrc = esrc; r.ews = ews;
      vec.push_back(r);
   endtask

   initial begin
      int gaps;
      // round-robin from reset: grants 0,1,0,1
      add(1,1,0,32'h11111111,32'h22222222, 1,0,8'h11,1,0,8'd0);
      for (int k = 0; k < 3; k++) add(1,1,0,32'h11111111,32'h22222222, 0,0,8'h11,1,0,8'd0);
      add(1,1,0,32'h11111111,32'h22222222, 0,1,8'h22,1,1,8'd1);
      for (int k = 0; k < 3; k++) add(1,1,0,32'h11111111,32'h22222222, 0,0,8'h22,1,1,8'd1);
      add(1,1,0,32'h11111111,32'h22222222, 1,0,8'h11,1,0,8'd2);
      for (int k = 0; k < 3; k++) add(1,1,0,32'h11111111,32'h22222222, 0,0,8'h11,1,0,8'd2);
      add(1,1,0,32'h11111111,32'h22222222, 0,1,8'h22,1,1,8'd3);
      for (int k = 0; k < 3; k++) add(1,1,0,32'h11111111,32'h22222222, 0,0,8'h22,1,1,8'd3);
      add(0,0,0,32'h0,32'h0, 0,0,8'h22,0,1,8'd4);
      // single word
      add(1,0,0,32'hA1B2C3D4,32'h0, 1,0,8'hA1,1,0,8'd4);
      add(0,0,0,32'hA1B2C3D4,32'h0, 0,0,8'hB2,1,0,8'd4);
      add(0,0,0,32'hA1B2C3D4,32'h0, 0,0,8'hC3,1,0,8'd4);
      add(0,0,0,32'hA1B2C3D4,32'h0, 0,0,8'hD4,1,0,8'd4);
      add(0,0,0,32'h0,32'h0, 0,0,8'hD4,0,0,8'd5);
      // pause for 3 cycles while in S2
      add(0,1,0,32'h0,32'hDEADBEEF, 0,1,8'hDE,1,1,8'd5);
      add(0,0,0,32'h0,32'hDEADBEEF, 0,0,8'hAD,1,1,8'd5);
      for (int k = 0; k < 3; k++) add(0,0,1,32'h0,32'hDEADBEEF, 0,0,8'hAD,0,1,8'd5);
      add(0,0,0,32'h0,32'hDEADBEEF, 0,0,8'hBE,1,1,8'd5);
      add(0,0,0,32'h0,32'hDEADBEEF, 0,0,8'hEF,1,1,8'd5);
      // pause in S0 blocks the grant; pop on first unpaused cycle
      add(0,1,1,32'h0,32'h12345678, 0,0,8'hEF,0,1,8'd5);
      add(0,1,0,32'h0,32'h12345678, 0,1,8'h12,1,1,8'd6);
      add(0,0,0,32'h0,32'h12345678, 0,0,8'h34,1,1,8'd6);
      add(0,0,0,32'h0,32'h12345678, 0,0,8'h56,1,1,8'd6);
      add(0,0,0,32'h0,32'h12345678, 0,0,8'h78,1,1,8'd6);
      add(0,0,0,32'h0,32'h0, 0,0,8'h78,0,1,8'd7);

      // reset state, pops gated even with a valid request
      reset_L = 1'b0; pause = 1'b0;
      valid_in0 = 1'b1; valid_in1 = 1'b0; data_in0 = 32'hFFFFFFFF; data_in1 = 32'h0;
      #2;
      chk("rst pop0", pop_0, 0);
      chk("rst data_out", data_out, 0);
      chk("rst valid_out", valid_out, 0);
      chk("rst src_out", src_out, 0);
      chk("rst words_sent", words_sent, 0);
      valid_in0 = 1'b0;
      @(negedge clk_4f); @(negedge clk_4f);
      reset_L = 1'b1;
      @(posedge clk_4f); #1;

      for (int i = 0; i < vec.size(); i++) begin
         valid_in0 = vec[i].v0; valid_in1 = vec[i].v1; pause = vec[i].pz;
         data_in0 = vec[i].d0;  data_in1 = vec[i].d1;
         #1;
         chk($sformatf("row%0d pop_0", i), pop_0, vec[i].ep0);
         chk($sformatf("row%0d pop_1", i), pop_1, vec[i].ep1);
         @(posedge clk_4f); #1;
         chk($sformatf("row%0d data_out", i), data_out, vec[i].edo);
         chk($sformatf("row%0d valid_out", i), valid_out, vec[i].evo);
         chk($sformatf("row%0d src_out", i), src_out, vec[i].esrc);
         chk($sformatf("row%0d words_sent", i), words_sent, vec[i].ews);
      end

      // asynchronous reset while in S2
      valid_in0 = 1'b1; data_in0 = 32'hAABBCCDD; pause = 1'b0;
      @(posedge clk_4f); #1;
      valid_in0 = 1'b0;
      @(posedge clk_4f); #1;
      chk("mid byte2", data_out, 8'hBB);
      #2;
      reset_L = 1'b0; valid_in0 = 1'b1;
      #1;
      chk("mid rst data_out", data_out, 0);
      chk("mid rst valid_out", valid_out, 0);
      chk("mid rst words_sent", words_sent, 0);
      chk("mid rst pop0", pop_0, 0);
      @(negedge clk_4f);
      reset_L = 1'b1;
      #1;
      chk("mid restart pop0", pop_0, 1);
      @(posedge clk_4f); #1;
      chk("mid restart byte3", data_out, 8'hAA);
      chk("mid restart valid", valid_out, 1);
      chk("mid restart ws", words_sent, 0);

      // 256 back-to-back words: counter wraps to 0
      reset_L = 1'b0; valid_in0 = 1'b0;
      @(negedge clk_4f);
      reset_L = 1'b1;
      @(posedge clk_4f); #1;
      valid_in0 = 1'b1; data_in0 = 32'h0F1E2D3C;
      gaps = 0;
      for (int e = 1; e <= 1024; e++) begin
         @(posedge clk_4f); #1;
         if (valid_out !== 1'b1) gaps++;
      end
      chk("wrap no bubble", gaps, 0);
      chk("wrap ws 255", words_sent, 8'd255);
      chk("wrap last byte", data_out, 8'h3C);
      valid_in0 = 1'b0;
      @(posedge clk_4f); #1;
      chk("wrap ws 0", words_sent, 8'd0);
      chk("wrap idle valid", valid_out, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
